// File: rtl/alu_cmd_seq_if.sv
// ============================================================================
// Module   : alu_cmd_seq_if
// Brief    : Command, result and ALU-port bundle for alu_cmd_seq
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic [2:0]  alu_d;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic [2:0]  out_d;
    logic [2:0]  out_op;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_c, alu_d, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_d, out_op
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_c, alu_d, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_d, out_op
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_seq.sv
// ============================================================================
// Module   : alu_cmd_seq
// Brief    : Command FIFO feeding an external combinational ALU, one result held
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_cmd_seq_if.slave             bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   mem_a  [DEPTH];
    logic [31:0]   mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          capture;
    logic          release_out;

    logic [31:0]   opnd_a;
    logic [31:0]   opnd_b;
    logic [2:0]    opnd_op;
    logic [31:0]   res_c;
    logic [2:0]    res_d;
    logic [2:0]    res_op;
    logic          res_valid;

    // Full blocks pushes even when a pop lands in the same cycle.
    assign bus.in_ready = (count < FULL);
    assign push         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= bus.in_a;
            mem_b[wr_ptr]  <= bus.in_b;
            mem_op[wr_ptr] <= bus.in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Operand registers keep the last popped command so the ALU inputs never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_a  <= '0;
            opnd_b  <= '0;
            opnd_op <= '0;
        end else if (pop) begin
            opnd_a  <= mem_a[rd_ptr];
            opnd_b  <= mem_b[rd_ptr];
            opnd_op <= mem_op[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_c     <= '0;
            res_d     <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
        end else if (capture) begin
            res_c     <= bus.alu_c;
            res_d     <= bus.alu_d;
            res_op    <= opnd_op;
            res_valid <= 1'b1;
        end else if (release_out) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.alu_a     = opnd_a;
    assign bus.alu_b     = opnd_b;
    assign bus.alu_op    = opnd_op;
    assign bus.out_c     = res_c;
    assign bus.out_d     = res_d;
    assign bus.out_op    = res_op;
    assign bus.out_valid = res_valid;
    assign busy          = (count != '0) || (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
// ============================================================================
// Module   : tb_alu_cmd_seq
// Brief    : Directed self-checking bench for alu_cmd_seq with a reference ALU
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       busy;
    int         checks;
    int         errors;

    alu_cmd_seq_if bus();

    alu_cmd_seq #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: d = {zero, negative, signed overflow of add/sub}.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] c;
        logic        ovf;
        c   = '0;
        ovf = 1'b0;
        case (op)
            3'b000: c = a << b[4:0];
            3'b001: c = $unsigned($signed(a) >>> b[4:0]);
            3'b010: begin
                c   = a + b;
                ovf = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b011: begin
                c   = a - b;
                ovf = (a[31] != b[31]) && (c[31] != a[31]);
            end
            3'b100: c = a * b;
            3'b101: c = a & b;
            3'b110: c = a | b;
            default: c = ~a;
        endcase
        return {(c == 32'd0), c[31], ovf, c};
    endfunction

    always_comb begin
        {bus.alu_d, bus.alu_c} = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, count, busy} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b cnt=%0d busy=%b want 1 0 0 0",
                     bus.in_ready, bus.out_valid, count, busy);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.out_c, bus.out_d, bus.out_op} !== '0) begin
            errors++;
            $display("FAIL reset_data: got alu_a=%h alu_b=%h op=%h out_c=%h want all zero",
                     bus.alu_a, bus.alu_b, bus.alu_op, bus.out_c);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single_add();
        bus.out_ready = 1'b1;
        drive_cmd(32'h0000_0001, 32'h0000_0002, 3'b010);
        checks++;
        if ({bus.out_valid, count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL add_n: got vld=%b cnt=%0d want 0 1", bus.out_valid, count);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op} !==
            {1'b0, 32'h1, 32'h2, 3'b010}) begin
            errors++;
            $display("FAIL add_n1: got vld=%b a=%h b=%h op=%b want 0 1 2 010",
                     bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_c, bus.out_d, bus.out_op} !==
            {1'b1, 32'h0000_0003, 3'b000, 3'b010}) begin
            errors++;
            $display("FAIL add_n2: got vld=%b c=%h d=%b op=%b want 1 00000003 000 010",
                     bus.out_valid, bus.out_c, bus.out_d, bus.out_op);
        end
        tick();
        checks++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL add_done: got vld=%b busy=%b want 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        drive_cmd(32'd5, 32'd6, 3'b010);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: got out_valid=%b want 1", bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_c, bus.out_d, bus.out_op, count} !==
                {1'b1, 32'd11, 3'b000, 3'b010, 3'd0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%b c=%h d=%b op=%b cnt=%0d want 1 0000000b 000 010 0",
                         i, bus.out_valid, bus.out_c, bus.out_d, bus.out_op, count);
            end
        end
    endtask

    task automatic test_fill();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [2:0]  vo [4];
        va = '{32'hFFFF_FFFF, 32'hF0F0_F0F0, 32'h0000_0000, 32'h4000_0001};
        vb = '{32'h0000_0000, 32'h0FF0_0FF0, 32'h0000_0000, 32'h0000_0001};
        vo = '{3'b111, 3'b101, 3'b110, 3'b000};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.in_ready);
            end
            drive_cmd(va[i], vb[i], vo[i]);
        end
        checks++;
        if ({count, bus.in_ready} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b want 4 0", count, bus.in_ready);
        end
        drive_cmd(32'h0000_0099, 32'h0000_0001, 3'b010);
        checks++;
        if ({count, bus.out_valid, bus.out_c} !== {3'd4, 1'b1, 32'd11}) begin
            errors++;
            $display("FAIL fill_fifth: got cnt=%0d vld=%b c=%h want 4 1 0000000b",
                     count, bus.out_valid, bus.out_c);
        end
    endtask

    task automatic test_full_pop();
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd7;
        bus.in_b      = 32'd8;
        bus.in_op     = 3'b010;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ready: got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if ({count, bus.out_valid, bus.in_ready} !== {3'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fullpop_after: got cnt=%0d vld=%b rdy=%b want 3 0 1",
                     count, bus.out_valid, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fullpop_accept: got cnt=%0d want 4", count);
        end
    endtask

    task automatic test_drain_order();
        logic [31:0] ec [5];
        logic [2:0]  ed [5];
        logic [2:0]  eo [5];
        int n;
        ec = '{32'h0000_0000, 32'h00F0_00F0, 32'h0000_0000, 32'h8000_0002, 32'h0000_000F};
        ed = '{3'b100, 3'b000, 3'b100, 3'b010, 3'b000};
        eo = '{3'b111, 3'b101, 3'b110, 3'b000, 3'b010};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!bus.out_valid && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if ({bus.out_valid, bus.out_c, bus.out_d, bus.out_op} !==
                {1'b1, ec[i], ed[i], eo[i]}) begin
                errors++;
                $display("FAIL drain[%0d]: got vld=%b c=%h d=%b op=%b want 1 %h %b %b",
                         i, bus.out_valid, bus.out_c, bus.out_d, bus.out_op, ec[i], ed[i], eo[i]);
            end
            tick();
        end
        tick();
        checks++;
        if ({count, busy, bus.out_valid} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_idle: got cnt=%0d busy=%b vld=%b want 0 0 0",
                     count, busy, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.out_ready = 1'b0;
        drive_cmd(32'h11, 32'h1, 3'b010);
        drive_cmd(32'h22, 32'h1, 3'b010);
        drive_cmd(32'h33, 32'h1, 3'b010);
        drive_cmd(32'h44, 32'h1, 3'b010);
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({count, bus.out_valid, bus.alu_a} !== {3'd2, 1'b0, 32'h22}) begin
            errors++;
            $display("FAIL rstmid_pre: got cnt=%0d vld=%b alu_a=%h want 2 0 00000022",
                     count, bus.out_valid, bus.alu_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_c, bus.out_d, bus.out_op, bus.alu_a, bus.alu_b,
             bus.alu_op, count, busy, bus.in_ready} !== {1'b0, 32'd0, 3'd0, 3'd0, 32'd0,
             32'd0, 3'd0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: got vld=%b c=%h alu_a=%h cnt=%0d busy=%b rdy=%b want 0 0 0 0 0 1",
                     bus.out_valid, bus.out_c, bus.alu_a, count, busy, bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ghost: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_sub_overflow();
        int n;
        bus.out_ready = 1'b1;
        drive_cmd(32'h8200_0000, 32'h3FFF_FFFF, 3'b011);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if ({bus.out_valid, bus.out_c, bus.out_d, bus.out_op} !==
            {1'b1, 32'h4200_0001, 3'b001, 3'b011}) begin
            errors++;
            $display("FAIL sub_ovf: got vld=%b c=%h d=%b op=%b want 1 42000001 001 011",
                     bus.out_valid, bus.out_c, bus.out_d, bus.out_op);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op} !==
            {1'b0, 32'h8200_0000, 32'h3FFF_FFFF, 3'b011}) begin
            errors++;
            $display("FAIL operand_hold: got vld=%b a=%h b=%h op=%b want 0 82000000 3fffffff 011",
                     bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_add();
        test_backpressure();
        test_fill();
        test_full_pop();
        test_drain_order();
        test_reset_mid();
        test_sub_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
